// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multicycle control unit.
//   - opcode_e : instruction opcodes (NOP..HALT)
//   - estado_e : FSM states of controle_multiciclo
//   - ALU operation and E-mux select codes
//   - bit positions of the instruction fields
package pkg_controle;

    typedef enum logic [3:0] {
        OpNop  = 4'h0,
        OpAdd  = 4'h1,
        OpSub  = 4'h2,
        OpAnd  = 4'h3,
        OpOr   = 4'h4,
        OpMov  = 4'h5,
        OpLdi  = 4'h6,
        OpJmp  = 4'h7,
        OpBz   = 4'h8,
        OpHalt = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        StOcioso  = 3'd0,
        StBusca   = 3'd1,
        StDecode  = 3'd2,
        StExec    = 3'd3,
        StEscrita = 3'd4,
        StParado  = 3'd5
    } estado_e;

    // ALU operation codes
    localparam logic [1:0] AluAdd = 2'd0;
    localparam logic [1:0] AluSub = 2'd1;
    localparam logic [1:0] AluAnd = 2'd2;
    localparam logic [1:0] AluOr  = 2'd3;

    // Bank input E mux select
    localparam logic [1:0] SelEAlu = 2'd0;
    localparam logic [1:0] SelEA   = 2'd1;
    localparam logic [1:0] SelEImm = 2'd2;

    // Instruction field positions; imm8 overlaps rb
    localparam int unsigned OpcodeHi = 15;
    localparam int unsigned OpcodeLo = 12;
    localparam int unsigned RcHi     = 11;
    localparam int unsigned RcLo     = 10;
    localparam int unsigned RaHi     = 9;
    localparam int unsigned RaLo     = 8;
    localparam int unsigned RbHi     = 7;
    localparam int unsigned RbLo     = 6;
    localparam int unsigned ImmHi    = 7;
    localparam int unsigned ImmLo    = 0;

endpackage

// File: rtl/decodificador_instr.sv
// Purely combinational instruction decoder.
// Ports:
//   ir          in  instruction register contents
//   alu_op      out ALU operation for ADD/SUB/AND/OR (ADD otherwise)
//   sel_e       out bank input E mux select
//   writes_reg  out instruction writes the register bank (ALU, MOV, LDI)
//   is_branch   out instruction may redirect the PC (JMP, BZ)
//   is_illegal  out opcode is not defined
module decodificador_instr
    import pkg_controle::*;
#(
    parameter int unsigned bits_palavra = 16
) (
    input  logic [bits_palavra-1:0] ir,
    output logic [1:0]              alu_op,
    output logic [1:0]              sel_e,
    output logic                    writes_reg,
    output logic                    is_branch,
    output logic                    is_illegal
);

    logic [3:0] opcode;
    assign opcode = ir[OpcodeHi:OpcodeLo];

    always_comb begin
        alu_op     = AluAdd;
        sel_e      = SelEAlu;
        writes_reg = 1'b0;
        is_branch  = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OpNop, OpHalt: ;
            OpAdd: begin
                alu_op     = AluAdd;
                writes_reg = 1'b1;
            end
            OpSub: begin
                alu_op     = AluSub;
                writes_reg = 1'b1;
            end
            OpAnd: begin
                alu_op     = AluAnd;
                writes_reg = 1'b1;
            end
            OpOr: begin
                alu_op     = AluOr;
                writes_reg = 1'b1;
            end
            OpMov: begin
                sel_e      = SelEA;
                writes_reg = 1'b1;
            end
            OpLdi: begin
                sel_e      = SelEImm;
                writes_reg = 1'b1;
            end
            OpJmp, OpBz: is_branch = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control unit: fetches instructions over a req/ack port, decodes
// them and sequences the 4x16 register bank and the ALU; owns the PC.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   inicio              start pulse, honoured only while idle
//   pc, imem_req        instruction address and fetch request
//   imem_ack, instr     instruction valid and instruction word
//   a_zero              bank output A is zero (BZ condition)
//   Sel_SA, Sel_SB      bank read selects
//   Sel_SC, Hab_Escrita bank write select and write enable
//   alu_op, sel_e, imm  datapath controls decoded from the IR
//   parado              machine halted
//   ilegal              one-cycle pulse on an undefined opcode
module controle_multiciclo
    import pkg_controle::*;
#(
    parameter int unsigned bits_palavra  = 16,
    parameter int unsigned end_registros = 2,
    parameter int unsigned bits_pc       = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     inicio,
    output logic [bits_pc-1:0]       pc,
    output logic                     imem_req,
    input  logic                     imem_ack,
    input  logic [bits_palavra-1:0]  instr,
    input  logic                     a_zero,
    output logic [end_registros-1:0] Sel_SA,
    output logic [end_registros-1:0] Sel_SB,
    output logic [end_registros-1:0] Sel_SC,
    output logic                     Hab_Escrita,
    output logic [1:0]               alu_op,
    output logic [1:0]               sel_e,
    output logic [7:0]               imm,
    output logic                     parado,
    output logic                     ilegal
);

    localparam logic [bits_pc-1:0] PcInc = bits_pc'(1);

    estado_e                 estado_q, estado_d;
    logic [bits_pc-1:0]      pc_q, pc_d;
    logic [bits_palavra-1:0] ir_q, ir_d;

    logic [1:0] dec_alu_op, dec_sel_e;
    logic       dec_writes_reg, dec_is_branch, dec_is_illegal;
    logic [3:0] opcode;
    logic [bits_pc-1:0] pc_imm;
    logic       em_operacao;

    decodificador_instr #(
        .bits_palavra (bits_palavra)
    ) u_decodificador (
        .ir         (ir_q),
        .alu_op     (dec_alu_op),
        .sel_e      (dec_sel_e),
        .writes_reg (dec_writes_reg),
        .is_branch  (dec_is_branch),
        .is_illegal (dec_is_illegal)
    );

    assign opcode = ir_q[OpcodeHi:OpcodeLo];
    assign pc_imm = bits_pc'(ir_q[ImmHi:ImmLo]);
    assign pc     = pc_q;

    // Operand selects and datapath controls are only driven while an
    // instruction is in flight, so everything reads zero when idle/halted.
    assign em_operacao = (estado_q == StDecode) || (estado_q == StExec) ||
                         (estado_q == StEscrita);
    assign Sel_SA = em_operacao ? end_registros'(ir_q[RaHi:RaLo]) : '0;
    assign Sel_SB = em_operacao ? end_registros'(ir_q[RbHi:RbLo]) : '0;
    assign alu_op = em_operacao ? dec_alu_op : AluAdd;
    assign sel_e  = em_operacao ? dec_sel_e  : SelEAlu;
    assign imm    = em_operacao ? ir_q[ImmHi:ImmLo] : 8'h00;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= StOcioso;
            pc_q     <= '0;
            ir_q     <= '0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
        end
    end

    always_comb begin
        estado_d    = estado_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        imem_req    = 1'b0;
        Hab_Escrita = 1'b0;
        Sel_SC      = '0;
        parado      = 1'b0;
        ilegal      = 1'b0;
        unique case (estado_q)
            StOcioso: begin
                if (inicio) estado_d = StBusca;
            end
            StBusca: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d     = instr;
                    estado_d = StDecode;
                end
            end
            // Gives the bank read and the ALU a cycle to settle.
            StDecode: estado_d = StExec;
            StExec: begin
                ilegal = dec_is_illegal;
                if (opcode == OpHalt) begin
                    estado_d = StParado;
                end else if (dec_writes_reg) begin
                    estado_d = StEscrita;
                end else begin
                    estado_d = StBusca;
                    if (dec_is_branch && ((opcode == OpJmp) || a_zero)) begin
                        pc_d = pc_imm;
                    end else begin
                        pc_d = pc_q + PcInc;
                    end
                end
            end
            StEscrita: begin
                Hab_Escrita = 1'b1;
                Sel_SC      = end_registros'(ir_q[RcHi:RcLo]);
                pc_d        = pc_q + PcInc;
                estado_d    = StBusca;
            end
            StParado: parado = 1'b1;
            default: estado_d = StOcioso;
        endcase
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
module tb_controle_multiciclo;

    logic        clock = 1'b0;
    logic        reset;
    logic        inicio;
    logic [7:0]  pc;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] instr;
    logic        a_zero;
    logic [1:0]  Sel_SA, Sel_SB, Sel_SC;
    logic        Hab_Escrita;
    logic [1:0]  alu_op, sel_e;
    logic [7:0]  imm;
    logic        parado, ilegal;

    int n_checks = 0;
    int n_pass   = 0;
    int n_escritas = 0;
    int n_escritas_esp = 0;
    logic [7:0] model_pc;

    controle_multiciclo dut (
        .clock       (clock),
        .reset       (reset),
        .inicio      (inicio),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .instr       (instr),
        .a_zero      (a_zero),
        .Sel_SA      (Sel_SA),
        .Sel_SB      (Sel_SB),
        .Sel_SC      (Sel_SC),
        .Hab_Escrita (Hab_Escrita),
        .alu_op      (alu_op),
        .sel_e       (sel_e),
        .imm         (imm),
        .parado      (parado),
        .ilegal      (ilegal)
    );

    always #5 clock = ~clock;

    // Every write-enable cycle seen at a clock edge is one bank write.
    always @(posedge clock) if (Hab_Escrita === 1'b1) n_escritas++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Reference semantics of the instruction set
    function automatic logic escreve(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd6);
    endfunction

    function automatic logic eh_ilegal(input logic [3:0] op);
        return (op >= 4'd9) && (op <= 4'd14);
    endfunction

    function automatic logic [1:0] alu_esp(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd4) ? 2'(op - 4'd1) : 2'd0;
    endfunction

    function automatic logic [1:0] sel_e_esp(input logic [3:0] op);
        if (op == 4'd5) return 2'd1;
        if (op == 4'd6) return 2'd2;
        return 2'd0;
    endfunction

    // Entered at a negedge in the fetch state; leaves at a negedge in the next
    // fetch state (or halted).
    task automatic run_instr(input logic [15:0] w, input logic az, input int atraso);
        logic [3:0] op;
        op = w[15:12];
        check("busca_req", imem_req, 1);
        check("busca_pc", pc, model_pc);
        check("busca_hab", Hab_Escrita, 0);
        a_zero   = ~az;
        imem_ack = 1'b0;
        instr    = 16'($urandom);
        for (int i = 0; i < atraso; i++) begin
            tick();
            check("espera_req", imem_req, 1);
            check("espera_pc", pc, model_pc);
            check("espera_hab", Hab_Escrita, 0);
        end
        imem_ack = 1'b1;
        instr    = w;
        tick();
        imem_ack = 1'b0;
        instr    = 16'($urandom);
        check("dec_req", imem_req, 0);
        check("dec_sa", Sel_SA, w[9:8]);
        check("dec_sb", Sel_SB, w[7:6]);
        check("dec_imm", imm, w[7:0]);
        // Only the value present during EXEC may matter for BZ.
        tick();
        a_zero   = az;
        imem_ack = 1'($urandom_range(0, 1));
        check("exec_ilegal", ilegal, eh_ilegal(op));
        check("exec_hab", Hab_Escrita, 0);
        check("exec_alu", alu_op, alu_esp(op));
        tick();
        a_zero   = ~az;
        imem_ack = 1'b0;
        check("pos_exec_ilegal", ilegal, 0);
        if (op == 4'hF) begin
            check("halt_parado", parado, 1);
            check("halt_req", imem_req, 0);
        end else if (escreve(op)) begin
            check("wb_hab", Hab_Escrita, 1);
            check("wb_sc", Sel_SC, w[11:10]);
            check("wb_sa", Sel_SA, w[9:8]);
            check("wb_sb", Sel_SB, w[7:6]);
            check("wb_alu", alu_op, alu_esp(op));
            check("wb_sel_e", sel_e, sel_e_esp(op));
            check("wb_imm", imm, w[7:0]);
            n_escritas_esp++;
            model_pc = model_pc + 8'd1;
            tick();
            check("pos_wb_hab", Hab_Escrita, 0);
            check("pos_wb_sc", Sel_SC, 0);
        end else begin
            if (op == 4'h7 || (op == 4'h8 && az)) model_pc = w[7:0];
            else model_pc = model_pc + 8'd1;
            check("sem_escrita_hab", Hab_Escrita, 0);
        end
    endtask

    task automatic start();
        inicio = 1'b1;
        tick();
        inicio = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        reset    = 1'b0;
        inicio   = 1'b0;
        imem_ack = 1'b0;
        instr    = 16'h0000;
        a_zero   = 1'b0;
        model_pc = 8'h00;
        @(negedge clock);
        @(negedge clock);
        check("reset_saidas", {pc, imem_req, Sel_SA, Sel_SB, Sel_SC, Hab_Escrita, alu_op,
                               sel_e, imm, parado, ilegal}, 0);
        reset = 1'b1;
        tick();
        check("ocioso_req", imem_req, 0);
        start();

        run_instr(16'h6105, 1'b0, 0);        // LDI r0,5
        run_instr(16'h1640, 1'b0, 0);        // ADD r1,r2,r1
        run_instr(16'h8020, 1'b1, 0);        // BZ taken
        run_instr(16'h8020, 1'b0, 0);        // BZ not taken
        run_instr(16'h2DC0, 1'b0, 5);        // ack after 5 wait cycles
        run_instr(16'hB000, 1'b0, 0);        // illegal
        run_instr(16'h70FF, 1'b0, 1);        // JMP 0xFF
        run_instr(16'h0000, 1'b0, 0);        // NOP wraps pc to 0
        for (int k = 0; k < 60; k++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'h0;
            run_instr(w, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end
        run_instr(16'h6105, 1'b0, 0);        // pc check for the last random one

        // Reset in the middle of a write cycle
        check("pre_abort_pc", pc, model_pc);
        imem_ack = 1'b1;
        instr    = 16'h6A05;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        check("abort_hab_antes", Hab_Escrita, 1);
        reset = 1'b0;
        #1;
        check("abort_hab", Hab_Escrita, 0);
        check("abort_sc", Sel_SC, 0);
        check("abort_pc", pc, 0);
        check("abort_req", imem_req, 0);
        @(negedge clock);
        reset = 1'b1;
        model_pc = 8'h00;
        tick();
        check("abort_ocioso", imem_req, 0);
        start();

        run_instr(16'h5400, 1'b0, 0);        // MOV r1,r0
        run_instr(16'hF000, 1'b0, 0);        // HALT
        inicio = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("parado_fixo", parado, 1);
            check("parado_req", imem_req, 0);
            check("parado_pc", pc, model_pc);
        end
        inicio = 1'b0;
        check("contagem_escritas", n_escritas, n_escritas_esp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
